// File: rtl/aes256_key_sched_ctrl.sv
// Sequencer for the dual-rail AES-256 key expansion: walks words 8..59 with a spacer
// before every evaluation and checks each returned round-constant word for rail integrity.
module aes256_key_sched_ctrl #(
  parameter int ROUND = 4,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr_fault,
  input  logic [WORD-1:0]  rcon_T,
  input  logic [WORD-1:0]  rcon_F,
  output logic [ROUND-1:0] round_T,
  output logic [ROUND-1:0] round_F,
  output logic [1:0]       op_T,
  output logic [1:0]       op_F,
  output logic [5:0]       word_idx,
  output logic             word_we,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_EVAL, S_DONE, S_FAULT} state_t;

  localparam logic [5:0] FIRST_W = 6'd8;
  localparam logic [5:0] LAST_W  = 6'd59;

  state_t           state;
  logic [WORD-1:0]  lane_ok;
  logic             rcon_ok;
  logic [1:0]       op_nxt;
  logic [ROUND-1:0] rnd_nxt;

  // Each rail pair must be exactly one-hot: never both low (spacer) nor both high.
  for (genvar g = 0; g < WORD; g++) begin : g_lane
    assign lane_ok[g] = (rcon_T[g] ^ rcon_F[g]) & ~(rcon_T[g] & rcon_F[g]);
  end
  assign rcon_ok = &lane_ok;

  assign word_we = (state == S_EVAL) && rcon_ok;

  // True-rail values for the word that the upcoming EVAL will produce.
  always_comb begin
    op_nxt  = 2'b00;
    rnd_nxt = '0;
    if (word_idx[2:0] == 3'd0) begin
      op_nxt  = 2'b10;
      rnd_nxt = ROUND'(word_idx[5:3]);
    end else if (word_idx[2:0] == 3'd4) begin
      op_nxt  = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      round_T  <= '0;
      round_F  <= '0;
      op_T     <= '0;
      op_F     <= '0;
      word_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_PRE;
            word_idx <= FIRST_W;
            busy     <= 1'b1;
          end
        end
        S_PRE: begin
          state   <= S_EVAL;
          op_T    <= op_nxt;
          op_F    <= ~op_nxt;
          round_T <= rnd_nxt;
          round_F <= ~rnd_nxt;
        end
        S_EVAL: begin
          // Rails drop back to the spacer whatever happens next.
          op_T    <= '0;
          op_F    <= '0;
          round_T <= '0;
          round_F <= '0;
          if (!rcon_ok) begin
            state <= S_FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else if (word_idx == LAST_W) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_PRE;
            word_idx <= word_idx + 6'd1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          word_idx <= '0;
        end
        S_FAULT: begin
          // word_idx keeps the failing word for debug until the fault is cleared.
          if (clr_fault) begin
            state    <= S_IDLE;
            fault    <= 1'b0;
            word_idx <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Randomized bench for aes256_key_sched_ctrl against a cycle-number based reference model.
module tb_aes256_key_sched_ctrl;

  localparam int ROUND = 4;
  localparam int WORD  = 32;

  localparam int K_IDLE  = 0;
  localparam int K_PRE   = 1;
  localparam int K_EVAL  = 2;
  localparam int K_DONE  = 3;
  localparam int K_FAULT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             clr_fault;
  logic [WORD-1:0]  rcon_T;
  logic [WORD-1:0]  rcon_F;
  logic [ROUND-1:0] round_T;
  logic [ROUND-1:0] round_F;
  logic [1:0]       op_T;
  logic [1:0]       op_F;
  logic [5:0]       word_idx;
  logic             word_we;
  logic             busy;
  logic             done;
  logic             fault;

  int n_tests = 0;
  int n_fail  = 0;

  aes256_key_sched_ctrl #(.ROUND(ROUND), .WORD(WORD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_fault(clr_fault),
    .rcon_T(rcon_T), .rcon_F(rcon_F),
    .round_T(round_T), .round_F(round_F), .op_T(op_T), .op_F(op_F),
    .word_idx(word_idx), .word_we(word_we), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [21:0] outs();
    return {round_T, round_F, op_T, op_F, word_idx, word_we, busy, done, fault};
  endfunction

  // Expected outputs from the state class and the word number, using the
  // key-schedule rules directly: every 8th word uses Rcon(w/8), every 4th SubWord.
  function automatic logic [21:0] model(input int kind, input int w, input bit we);
    logic [3:0] r;
    logic [1:0] op;
    logic [5:0] idx;
    r = 4'd0;
    op = 2'd0;
    if (kind == K_EVAL) begin
      if (w % 8 == 0) begin
        op = 2'd2;
        r  = 4'(w / 8);
      end else if (w % 8 == 4) begin
        op = 2'd1;
      end
    end
    idx = (kind == K_IDLE) ? 6'd0 : 6'(w);
    if (kind == K_EVAL)
      return {r, ~r, op, ~op, idx, we, 1'b1, 1'b0, 1'b0};
    return {4'd0, 4'd0, 2'd0, 2'd0, idx, 1'b0,
            kind == K_PRE, kind == K_DONE, kind == K_FAULT};
  endfunction

  task automatic good_rcon();
    rcon_T = $urandom;
    rcon_F = ~rcon_T;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      clr_fault = 1'($urandom_range(0, 1));
      good_rcon();
      @(negedge clk);
      chk("idle", 64'(outs()), 64'(model(K_IDLE, 0, 1'b0)));
    end
  endtask

  // One expansion. fault_w: word whose lookup is corrupted (-1 none);
  // noise_c: cycle with a forced extra start; abort_w: word where reset hits.
  task automatic do_run(input int fault_w, input int noise_c, input int abort_w, input bit spec_bad);
    int  kind;
    int  w;
    bit  bad;
    @(posedge clk); #1;
    start = 1'b1;
    clr_fault = 1'b0;
    good_rcon();
    @(negedge clk);
    chk("idle_at_start", 64'(outs()), 64'(model(K_IDLE, 0, 1'b0)));
    for (int c = 1; c <= 105; c++) begin
      if (c == 105) begin
        kind = K_DONE; w = 59;
      end else if (c % 2 == 1) begin
        kind = K_PRE;  w = 8 + (c - 1) / 2;
      end else begin
        kind = K_EVAL; w = 7 + c / 2;
      end
      @(posedge clk); #1;
      start = (c == noise_c) || ($urandom_range(0, 5) == 0);
      clr_fault = 1'($urandom_range(0, 1));
      bad = (kind == K_EVAL) && (w == fault_w);
      if (bad && spec_bad) begin
        rcon_T = 32'h0100_0000;
        rcon_F = 32'hFF00_0000;
      end else if (bad) begin
        rcon_T = $urandom;
        rcon_F = ~rcon_T ^ (32'd1 << $urandom_range(0, 31));
      end else begin
        good_rcon();
      end
      @(negedge clk);
      chk($sformatf("run_c%0d", c), 64'(outs()), 64'(model(kind, w, !bad)));
      if (kind == K_EVAL && w == abort_w) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'(outs()), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", 64'(outs()), 64'(model(K_IDLE, 0, 1'b0)));
        return;
      end
      if (bad) begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          start = 1'b1;
          clr_fault = 1'b0;
          good_rcon();
          @(negedge clk);
          chk("fault_hold", 64'(outs()), 64'(model(K_FAULT, fault_w, 1'b0)));
        end
        @(posedge clk); #1;
        start = 1'b1;
        clr_fault = 1'b1;
        @(negedge clk);
        chk("fault_clr_cycle", 64'(outs()), 64'(model(K_FAULT, fault_w, 1'b0)));
        @(posedge clk); #1;
        start = 1'b0;
        clr_fault = 1'b0;
        @(negedge clk);
        chk("fault_cleared", 64'(outs()), 64'(model(K_IDLE, 0, 1'b0)));
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clr_fault = 1'b0;
    good_rcon();
    #1 chk("reset_async", 64'(outs()), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    idle_cycles(3);

    do_run(-1, -1, -1, 1'b0);
    idle_cycles(2);
    do_run(-1, 50, -1, 1'b0);
    idle_cycles(2);
    do_run(16, -1, -1, 1'b1);
    idle_cycles(2);
    do_run(-1, -1, 30, 1'b0);
    do_run(-1, -1, -1, 1'b0);
    do_run(-1, -1, -1, 1'b0);
    idle_cycles(2);
    for (int k = 0; k < 4; k++) begin
      do_run($urandom_range(8, 59), -1, -1, 1'b0);
      idle_cycles(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
